cm0_wic_ctrl: RTL and testbench

//  Wake-up interrupt controller; sits directly downstream of the Cortex-M0 macro-cell's WIC port.

---
 rtl/cm0_wic_pkg.sv | 18 +
 rtl/cm0_wic_ctrl_if.sv | 41 ++++
 rtl/cm0_wic_sync.sv | 26 ++
 rtl/cm0_wic_ctrl.sv | 116 +++++++++++
 tb/tb_cm0_wic_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cm0_wic_pkg.sv
// Shared definitions for the Cortex-M0 wake-up interrupt controller:
// FSM state encoding and the bit positions of the sensed wake lines.
package cm0_wic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_WAKE  = 2'd2
   } wic_state_e;

   localparam int WIC_RXEV = 0;
   localparam int WIC_NMI  = 1;
   localparam int WIC_IRQ0 = 2;

   localparam int WIC_LINES_MIN = 2;
   localparam int WIC_LINES_MAX = 34;

endpackage

// File: rtl/cm0_wic_ctrl_if.sv
// Signal bundle between the core/PMU side and the wake-up interrupt controller.
interface cm0_wic_ctrl_if #(
   parameter int WICLINES = 34
);
   logic                wic_enable_i;
   logic                wic_ds_req_n_o;
   logic                wic_ds_ack_n_i;
   logic                wic_load_i;
   logic                wic_clear_i;
   logic [WICLINES-1:0] wic_mask_i;
   logic [WICLINES-1:0] sense_i;
   logic                sleeping_i;
   logic                wakeup_o;
   logic [WICLINES-1:0] wic_pend_o;

   modport slave (
      input  wic_enable_i,
      input  wic_ds_ack_n_i,
      input  wic_load_i,
      input  wic_clear_i,
      input  wic_mask_i,
      input  sense_i,
      input  sleeping_i,
      output wic_ds_req_n_o,
      output wakeup_o,
      output wic_pend_o
   );

   modport master (
      output wic_enable_i,
      output wic_ds_ack_n_i,
      output wic_load_i,
      output wic_clear_i,
      output wic_mask_i,
      output sense_i,
      output sleeping_i,
      input  wic_ds_req_n_o,
      input  wakeup_o,
      input  wic_pend_o
   );
endinterface

// File: rtl/cm0_wic_sync.sv
// WIDTH-wide two-flop synchroniser bank for the raw, possibly asynchronous wake lines.
module cm0_wic_sync #(
   parameter int WIDTH = 34
) (
   input  logic             sclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/cm0_wic_ctrl.sv
// Wake-up interrupt controller: latches the core's WIC mask on load, watches the
// sensed lines during deep sleep and raises wakeup_o plus sticky pending bits.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | not armed; mask and pending cleared, no wake request
// ST_ARMED | mask latched, core in WIC deep sleep, waiting for a hit
// ST_WAKE  | hit seen; wakeup_o held, pending accumulates until core wakes
module cm0_wic_ctrl
   import cm0_wic_pkg::*;
#(
   parameter int WICLINES = 34,
   parameter int SYNC     = 1
) (
   input  logic            sclk,
   input  logic            reset,
   cm0_wic_ctrl_if.slave   wic
);

   wic_state_e          state_q, state_d;
   logic [WICLINES-1:0] mask_q, mask_d;
   logic [WICLINES-1:0] pend_q, pend_d;
   logic                wake_q, wake_d;
   logic                ds_req_n_q;
   logic [WICLINES-1:0] s;
   logic [WICLINES-1:0] hit;
   logic                clr_all;

   generate
      if (SYNC != 0) begin : g_sync
         cm0_wic_sync #(.WIDTH(WICLINES)) u_sync (
            .sclk  (sclk),
            .reset (reset),
            .d     (wic.sense_i),
            .q     (s)
         );
      end else begin : g_nosync
         assign s = wic.sense_i;
      end
   endgenerate

   assign hit = s & mask_q;

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mask_q     <= '0;
         pend_q     <= '0;
         wake_q     <= 1'b0;
         ds_req_n_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         wake_q     <= wake_d;
         ds_req_n_q <= ~wic.wic_enable_i;
      end
   end

   // Clear wins over everything, including a hit or load on the same edge.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      pend_d  = pend_q;
      wake_d  = wake_q;
      clr_all = 1'b0;

      if (wic.wic_clear_i) begin
         clr_all = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (wic.wic_load_i && !wic.wic_ds_ack_n_i && wic.wic_enable_i) begin
                  state_d = ST_ARMED;
                  mask_d  = wic.wic_mask_i;
                  pend_d  = '0;
               end
            end
            ST_ARMED: begin
               if (!wic.wic_enable_i) begin
                  clr_all = 1'b1;
               end else if (|hit) begin
                  state_d = ST_WAKE;
                  pend_d  = hit;
                  wake_d  = 1'b1;
               end else if (wic.wic_load_i) begin
                  mask_d  = wic.wic_mask_i;
               end
            end
            ST_WAKE: begin
               // Enable dropping does not abort a wake; only the core waking does.
               if (!wic.sleeping_i) begin
                  clr_all = 1'b1;
               end else begin
                  pend_d  = pend_q | hit;
               end
            end
            default: begin
               clr_all = 1'b1;
            end
         endcase
      end

      if (clr_all) begin
         state_d = ST_IDLE;
         mask_d  = '0;
         pend_d  = '0;
         wake_d  = 1'b0;
      end
   end

   assign wic.wic_ds_req_n_o = ds_req_n_q;
   assign wic.wakeup_o       = wake_q;
   assign wic.wic_pend_o     = pend_q;

endmodule

// File: tb/tb_cm0_wic_ctrl.sv
// Scoreboard bench for cm0_wic_ctrl: a 34-line synchronised instance and a 2-line
// direct-input instance share control stimulus and are checked against a rule model.
module tb_cm0_wic_ctrl;

   logic sclk = 1'b0;
   logic reset;
   always #5 sclk = ~sclk;

   cm0_wic_ctrl_if #(.WICLINES(34)) ifa ();
   cm0_wic_ctrl_if #(.WICLINES(2))  ifb ();

   cm0_wic_ctrl #(.WICLINES(34), .SYNC(1)) dut_a (.sclk(sclk), .reset(reset), .wic(ifa));
   cm0_wic_ctrl #(.WICLINES(2),  .SYNC(0)) dut_b (.sclk(sclk), .reset(reset), .wic(ifb));

   typedef struct {
      int          d;
      logic        rq;
      logic        wk;
      logic [33:0] pend;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   event ev_async;
   int   checks = 0;
   int   errors = 0;

   logic        en, ld, clr, ackn, slp;
   logic [33:0] msk [2];
   logic [33:0] sns [2];
   logic [33:0] wm  [2];

   // reference model: one set of rule variables per instance
   bit          m_armed [2];
   bit          m_wake  [2];
   logic        m_reqn  [2];
   logic [33:0] m_mask  [2];
   logic [33:0] m_pend  [2];
   logic [33:0] h1      [2];
   logic [33:0] h2      [2];

   task automatic apply();
      ifa.wic_enable_i   = en;  ifb.wic_enable_i   = en;
      ifa.wic_load_i     = ld;  ifb.wic_load_i     = ld;
      ifa.wic_clear_i    = clr; ifb.wic_clear_i    = clr;
      ifa.wic_ds_ack_n_i = ackn; ifb.wic_ds_ack_n_i = ackn;
      ifa.sleeping_i     = slp; ifb.sleeping_i     = slp;
      ifa.wic_mask_i     = msk[0];
      ifa.sense_i        = sns[0];
      ifb.wic_mask_i     = msk[1][1:0];
      ifb.sense_i        = sns[1][1:0];
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_armed[d] = 0; m_wake[d] = 0; m_reqn[d] = 1'b1;
         m_mask[d] = '0; m_pend[d] = '0; h1[d] = '0; h2[d] = '0;
      end
   endtask

   task automatic model_drop(input int d);
      m_armed[d] = 0; m_wake[d] = 0; m_mask[d] = '0; m_pend[d] = '0;
   endtask

   // Sensed value seen by the controller lags the pins by two edges when synchronised.
   task automatic model_edge(input int d, input bit syn);
      logic [33:0] s, hit;
      s = syn ? h2[d] : (sns[d] & wm[d]);
      if (syn) begin
         h2[d] = h1[d];
         h1[d] = sns[d] & wm[d];
      end
      hit = s & m_mask[d];
      m_reqn[d] = ~en;
      if (clr) model_drop(d);
      else if (m_wake[d]) begin
         if (!slp) model_drop(d);
         else m_pend[d] = m_pend[d] | hit;
      end else if (m_armed[d]) begin
         if (!en) model_drop(d);
         else if (hit != 0) begin
            m_armed[d] = 0; m_wake[d] = 1; m_pend[d] = hit;
         end else if (ld) m_mask[d] = msk[d] & wm[d];
      end else if (ld && !ackn && en) begin
         m_armed[d] = 1; m_mask[d] = msk[d] & wm[d]; m_pend[d] = '0;
      end
   endtask

   task automatic push_exp(input string tag);
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         e.d = d; e.rq = m_reqn[d]; e.wk = m_wake[d]; e.pend = m_pend[d]; e.tag = tag;
         sbq.push_back(e);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge sclk);
      #1;
      if (reset) model_reset();
      else begin
         model_edge(0, 1'b1);
         model_edge(1, 1'b0);
      end
      push_exp(tag);
   endtask

   task automatic chk(input string name, input int d, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, d, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t        e;
      logic        a_rq, a_wk;
      logic [33:0] a_pend;
      forever begin
         @(negedge sclk or ev_async);
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.d == 0) begin
               a_rq = ifa.wic_ds_req_n_o; a_wk = ifa.wakeup_o; a_pend = ifa.wic_pend_o;
            end else begin
               a_rq = ifb.wic_ds_req_n_o; a_wk = ifb.wakeup_o; a_pend = {32'b0, ifb.wic_pend_o};
            end
            chk({e.tag, ".req_n"},  e.d, {33'b0, a_rq}, {33'b0, e.rq});
            chk({e.tag, ".wakeup"}, e.d, {33'b0, a_wk}, {33'b0, e.wk});
            chk({e.tag, ".pend"},   e.d, a_pend, e.pend);
         end
      end
   end

   initial begin : stim
      wm[0] = {34{1'b1}};
      wm[1] = 34'h3;
      reset = 1'b1;
      en = 0; ld = 0; clr = 0; ackn = 1; slp = 1;
      msk[0] = '0; msk[1] = '0; sns[0] = '0; sns[1] = '0;
      apply();
      model_reset();
      #1;
      push_exp("reset");
      -> ev_async;
      tick("reset_hold");
      tick("reset_hold");
      reset = 1'b0;

      // 1: enable, arm on IRQ0, wake three edges after the line rises
      en = 1; apply(); tick("t1_req");
      ackn = 0; ld = 1; msk[0] = 34'h4; msk[1] = 34'h1; apply(); tick("t1_load");
      ld = 0; sns[0] = 34'h4; apply();
      repeat (4) tick("t1_wake");
      sns[0] = '0; apply(); tick("t1_hold");
      slp = 0; apply(); tick("t1_exit");
      slp = 1; apply(); tick("t1_idle");

      // 2: NMI-only mask ignores IRQ5, wakes on NMI, exits when core wakes
      ld = 1; msk[0] = 34'h2; apply(); tick("t2_load");
      ld = 0; sns[0] = 34'h1 << 7; apply(); tick("t2_irq5");
      sns[0] = '0; apply(); repeat (3) tick("t2_nohit");
      sns[0] = 34'h2; apply(); tick("t2_nmi");
      sns[0] = '0; apply(); repeat (3) tick("t2_wake");
      slp = 0; apply(); tick("t2_exit");
      slp = 1; apply(); tick("t2_idle");

      // 3: load and clear together while armed
      ld = 1; apply(); tick("t3_load");
      ld = 1; clr = 1; apply(); tick("t3_ldclr");
      ld = 0; clr = 0; sns[0] = 34'h2; sns[1] = 34'h2; apply();
      repeat (4) tick("t3_nowake");
      sns[0] = '0; sns[1] = '0; apply();

      // 4: load ignored while ack is high
      ackn = 1; ld = 1; msk[0] = {34{1'b1}}; msk[1] = 34'h3; apply(); tick("t4_load");
      ld = 0;
      for (int i = 0; i < 5; i++) begin
         sns[0] = {2'($urandom_range(3, 0)), 32'($urandom)};
         sns[1] = 34'($urandom_range(3, 0));
         apply(); tick("t4_idle");
      end
      sns[0] = '0; sns[1] = '0; ackn = 0; apply(); tick("t4_end");

      // 5: sticky accumulate in WAKE, then asynchronous reset
      ld = 1; msk[0] = 34'h5; msk[1] = 34'h0; apply(); tick("t5_load");
      ld = 0; sns[0] = 34'h4; apply(); repeat (4) tick("t5_irq0");
      sns[0] = 34'h1; apply(); repeat (3) tick("t5_rxev");
      @(negedge sclk);
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      push_exp("t5_async_rst");
      -> ev_async;
      sns[0] = '0; apply();
      tick("t5_rst_hold");
      reset = 1'b0;
      tick("t5_after");

      // 6: direct-input instance captures a one-cycle RXEV pulse on its edge
      ld = 1; msk[0] = 34'h0; msk[1] = 34'h1; apply(); tick("t6_load");
      ld = 0; apply(); tick("t6_armed");
      sns[1] = 34'h1; apply(); tick("t6_pulse");
      sns[1] = '0; apply(); tick("t6_hold");
      slp = 0; apply(); tick("t6_exit");
      slp = 1; apply();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(99) < 95);
         ackn = ($urandom_range(99) < 15);
         ld   = ($urandom_range(99) < 10);
         clr  = ($urandom_range(99) < 3);
         slp  = ($urandom_range(99) >= 8);
         if ($urandom_range(1) == 1)
            msk[0] = 34'h1 << $urandom_range(33);
         else
            msk[0] = {2'($urandom_range(3, 0)), 32'($urandom)} & {2'($urandom_range(3, 0)), 32'($urandom)};
         msk[1] = 34'($urandom_range(3, 0));
         sns[0] = ($urandom_range(99) < 25) ? (34'h1 << $urandom_range(33)) : 34'h0;
         sns[1] = ($urandom_range(99) < 25) ? 34'($urandom_range(3, 0)) : 34'h0;
         apply();
         tick("rand");
      end

      en = 0; ld = 0; clr = 0; sns[0] = '0; sns[1] = '0; apply();
      repeat (2) tick("drain");
      @(negedge sclk);
      #1;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
